// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//   Handshake/bus bundle for one generic pipeline stage register.
//   Upstream side : in_valid, in_ready, in_ctrl, in_data
//   Downstream side: out_valid, out_ready, out_ctrl, out_data
//   Handshake: a beat moves across a boundary on a rising clock edge where
//   valid and ready are both 1. The sender holds valid and the payload
//   stable until that happens. ready never depends combinationally on the
//   valid signal of the same boundary.
//   Modports:
//     slave  - the stage register itself. It consumes in_* and produces out_*.
//     master - the surrounding pipeline or bench. It produces in_* and
//              consumes out_*.
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register with a 2-entry skid buffer. It carries a
//   control bundle and a data bundle from one stage to the next. in_ready
//   comes straight from a flop, so a downstream stall reaches the upstream
//   stage without any combinational path from out_ready.
//
//   Ports:
//     clock     - rising-edge clock
//     reset     - synchronous, active-low reset. It has the highest priority
//                 and clears every valid bit, every ctrl bit and every data bit.
//     flush     - synchronous bubble insertion. It clears the valid bits and
//                 the ctrl bits, and it drops any beat offered in the same
//                 cycle. The data registers keep their values.
//     bus       - pipe_stage_reg_if.slave (in_* upstream, out_* downstream)
//     stall_cnt - 32-bit count of cycles with out_valid=1 and out_ready=0.
//                 It wraps, and only reset clears it. This port exists only
//                 when PIPE_PERF_CNT_EN is defined.
//
//   Optional feature macro: PIPE_PERF_CNT_EN (adds the stall counter).
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  pipe_stage_reg_if.slave    bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic              main_v_q,    main_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_v_q,    skid_v_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic emit;

  // The skid entry is the only thing that can refuse a beat. Because
  // skid_v_q is a flop, in_ready is registered.
  assign bus.in_ready  = !skid_v_q;
  assign bus.out_valid = main_v_q;
  // A bubble must never assert RegWrite/WREN/RDEN downstream.
  assign bus.out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign bus.out_data  = main_data_q;

  assign accept = bus.in_valid & !skid_v_q;
  assign emit   = main_v_q & bus.out_ready;

  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Both the offered beat and any concurrent emit are discarded.
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
      skid_v_d    = 1'b0;
      skid_ctrl_d = '0;
    end else if (emit && skid_v_q) begin
      // in_ready is 0 here, so no accept can coincide with this move.
      main_v_d    = 1'b1;
      main_ctrl_d = skid_ctrl_q;
      main_data_d = skid_data_q;
      skid_v_d    = 1'b0;
    end else if (emit && accept) begin
      main_v_d    = 1'b1;
      main_ctrl_d = bus.in_ctrl;
      main_data_d = bus.in_data;
    end else if (emit) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
    end else if (accept && !main_v_q) begin
      main_v_d    = 1'b1;
      main_ctrl_d = bus.in_ctrl;
      main_data_d = bus.in_data;
    end else if (accept) begin
      // The main entry is stalled, so the beat parks in the skid entry.
      skid_v_d    = 1'b1;
      skid_ctrl_d = bus.in_ctrl;
      skid_data_d = bus.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // This counts a presented-but-refused beat, including one that a flush
  // discards in the same cycle. A flush never clears the count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_v_q && !bus.out_ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 96;
  localparam int BEAT_W = CTRL_W + DATA_W;

  logic clock;
  logic reset;
  logic flush;

  pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus.slave)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [BEAT_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input bit expect_out);
    bus.in_valid = 1'b1;
    bus.in_ctrl  = c;
    bus.in_data  = d;
    if (expect_out) exp_q.push_back({c, d});
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_ctrl  = '0;
    bus.in_data  = '0;
  endtask

  // ---------------- monitor ----------------
  // Runs on the falling edge. It pops the scoreboard for every beat that the
  // next rising edge will hand downstream. A flushed emit does not count.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (bus.out_valid !== 1'b1) begin
        chk("bubble_ctrl_zero", bus.out_ctrl, '0);
      end else if (bus.out_ready === 1'b1 && flush !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got ctrl 0x%0h data 0x%0h expected none", bus.out_ctrl, bus.out_data);
        end else begin
          logic [BEAT_W-1:0] e;
          e = exp_q.pop_front();
          chk("out_beat", {bus.out_ctrl, bus.out_data}, e);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 8'hFF;
    bus.in_data   = '1;

    // Reset is held for two edges while a beat is offered.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_ctrl",  bus.out_ctrl, 8'h00);
      chk("rst_out_data",  bus.out_data, '0);
      chk("rst_in_ready",  bus.in_ready, 1'b1);
    end
`ifdef PIPE_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // The first beat after reset appears one cycle later.
    reset = 1'b1;
    offer(8'h01, 96'h1, 1'b1);
    step();
    chk("first_beat_latency", bus.out_valid, 1'b1);
    chk("first_beat_ctrl", bus.out_ctrl, 8'h01);

    // Streaming: 8 beats back to back, no gaps.
    for (int i = 1; i <= 8; i++) begin
      offer(8'(8'h10 + i), 96'(i), 1'b1);
      chk("stream_in_ready", bus.in_ready, 1'b1);
      step();
      chk("stream_no_gap", bus.out_valid, 1'b1);
      chk("stream_data", bus.out_data, 96'(i));
    end
    idle_in();
    step();
    step();
    chk("drained_valid", bus.out_valid, 1'b0);
    chk("drained_ctrl",  bus.out_ctrl, 8'h00);

    // Stall: A goes to main, B goes to skid, then both drain in order.
    bus.out_ready = 1'b0;
    offer(8'h21, 96'hA, 1'b1);
    step();
    offer(8'h22, 96'hB, 1'b1);
    chk("stall_in_ready_b", bus.in_ready, 1'b1);
    step();
    idle_in();
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_out_ctrl", bus.out_ctrl, 8'h21);
    step();
    chk("held_in_ready", bus.in_ready, 1'b0);
    chk("held_out_data", bus.out_data, 96'hA);
    bus.out_ready = 1'b1;
    step();
    chk("skid_to_main_ctrl", bus.out_ctrl, 8'h22);
    chk("ready_returns", bus.in_ready, 1'b1);
    step();
    chk("stall_drained", bus.out_valid, 1'b0);

    // Flush with both entries full while a third beat is offered.
    bus.out_ready = 1'b0;
    offer(8'h3C, 96'hC, 1'b0);
    step();
    offer(8'h5A, 96'hD, 1'b0);
    step();
    offer(8'h77, 96'hE, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_out_ctrl",  bus.out_ctrl, 8'h00);
    chk("flush_in_ready",  bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    step();
    step();
    step();

    // Flush while in_ready=1: the beat offered in the same cycle is dropped.
    bus.out_ready = 1'b0;
    offer(8'h44, 96'hF, 1'b0);
    step();
    offer(8'h45, 96'h10, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    chk("flush2_out_valid", bus.out_valid, 1'b0);
    chk("flush2_in_ready",  bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    step();
    step();

    // Reset while stalled with both entries full.
    bus.out_ready = 1'b0;
    offer(8'h61, 96'h61, 1'b0);
    step();
    offer(8'h62, 96'h62, 1'b0);
    step();
    idle_in();
    chk("pre_reset_full", bus.in_ready, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_in_ready",  bus.in_ready, 1'b1);
    chk("midrst_out_data",  bus.out_data, '0);
`ifdef PIPE_PERF_CNT_EN
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
`endif
    bus.out_ready = 1'b1;
    step();
    step();

`ifdef PIPE_PERF_CNT_EN
    // Five stall cycles are counted, a flush keeps the count, and the
    // counter wraps from all ones to zero.
    bus.out_ready = 1'b0;
    offer(8'h71, 96'h71, 1'b1);
    step();
    idle_in();
    for (int i = 0; i < 5; i++) step();
    chk("stall_cnt_5", stall_cnt, 32'd5);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    chk("stall_cnt_after_flush", stall_cnt, 32'd5);
    bus.out_ready = 1'b0;
    offer(8'h72, 96'h72, 1'b1);
    step();
    idle_in();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    step();
    chk("stall_cnt_wrap", stall_cnt, 32'd0);
    bus.out_ready = 1'b1;
    step();
    step();
`endif

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control bundle and a data bundle between stages and adds a valid/ready handshake with a 2-entry skid buffer. This lets a downstream stall propagate upstream without a combinational ready path. A flush input inserts a bubble: all valid bits are cleared and the control bundle is zeroed.

Parameters:
CTRL_W, 8, width of control bundle (RegWrite, MemToReg, WREN, RDEN, ALUOp, ...); zeroed on flush/reset
DATA_W, 96, width of data bundle (operands, immediate, register addresses, ...)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
flush  input  1  synchronous flush; bubble insertion
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat; registered
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts (0 = stall)
out_ctrl  output  CTRL_W  control bundle to next stage; all zeros whenever out_valid=0
out_data  output  DATA_W  data bundle to next stage
stall_cnt  output  32  stall-cycle counter (only with PIPE_PERF_CNT_EN)

Behaviour:
- One clock, synchronous active-low reset: all state changes on rising edge of clock; reset sampled only at the edge.
- Storage:
  - main entry: main_v, main_ctrl, main_data; drives out_*.
  - skid entry: skid_v, skid_ctrl, skid_data.
- in_ready = !skid_v, registered (no combinational path from out_ready).
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Next state, when not reset and not flush:
  - emit and skid_v: main <= skid; skid_v <= 0. A concurrent accept is impossible (in_ready=0).
  - emit, !skid_v, accept: main <= in; main_v <= 1.
  - emit, no accept: main_v <= 0; main_ctrl <= 0.
  - !emit, accept, !main_v: main <= in; main_v <= 1.
  - !emit, accept, main_v: skid <= in; skid_v <= 1 (in_ready falls next cycle).
  - otherwise: hold.
- Latency: 1 cycle in to out when unstalled. Full throughput: 1 beat/cycle with out_ready held high.
- Ordering: beats leave in arrival order; none dropped or duplicated except on flush.
- Boundary conditions:
  - full (main_v & skid_v): in_ready=0; upstream must hold.
  - empty: out_valid=0, out_ctrl=0.
- Flush (flush=1 at an edge):
  - main_v, skid_v <= 0; main_ctrl, skid_ctrl <= 0; data registers hold.
  - A beat offered in the same cycle is dropped even if in_valid=1.
  - A concurrent emit is treated as not having happened; the downstream must also be flushed by the hazard unit.
- Reset (reset=0 at an edge): highest priority over flush and all transfers.
  - All valid bits, ctrl and data cleared to 0.
  - in_ready=1 from the first cycle after reset.
  - Mid-stall reset discards both entries.
- out_ctrl is forced to 0 whenever main_v=0, so a bubble never asserts RegWrite/WREN/RDEN downstream.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cnt port exists.
  - 32-bit counter increments on every cycle with out_valid=1 and out_ready=0; wraps 0xFFFFFFFF -> 0.
  - Cleared by reset only, not by flush.
- Undefined: stall_cnt port and counter are absent; no other behaviour changes.

Test Plan:
- Reset low 2 cycles with in_valid=1, in_ctrl=0xFF -> out_valid=0, out_ctrl=0x00, out_data=0, in_ready=1; after release, first beat (ctrl 0x01, data 0x1) appears 1 cycle later.
- out_ready=1, in_valid=1 for 8 cycles, data 1..8 -> out_data 1..8 on consecutive cycles, no gaps, in_ready stays 1.
- Stall: out_ready=0 while beats A,B offered -> A in main, B in skid, in_ready=0 next cycle; out_ready=1 -> A then B emitted in order, in_ready returns to 1 the cycle after B moves to main.
- Flush with main and skid full (ctrl 0x3C, 0x5A) and a third beat offered -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1; third beat never appears.
- Reset asserted mid-stall (both entries full) -> out_valid=0, in_ready=1, stall_cnt=0 next cycle.
- PIPE_PERF_CNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; flush -> stall_cnt stays 5; preload near 0xFFFFFFFF by force -> wraps to 0.
